// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, register count, writeback record and
// writeback source encoding.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int RIDX_W = $clog2(NREG);

    typedef logic [RIDX_W-1:0] reg_idx_t;

    // One pending register-file write.
    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, push/pop, full/empty and
// occupancy count. DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // Overflow/underflow requests are ignored rather than corrupting state.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. ALU results have fixed priority over load
// results, which are buffered in a small FIFO. A pending-load bitmap (busy)
// lets issue detect hazards on registers whose load is still in flight.
// Optional: define WB_TRACE_EN for a simulation-only per-write trace print.
// XLEN must match cpu_pkg::XLEN since results travel as cpu_pkg::wb_req_t.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int NREG     = cpu_pkg::NREG,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  reg_idx_t        alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  reg_idx_t        ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_ld,
    input  reg_idx_t        iss_rd,
    output logic [NREG-1:0] busy,
    output logic [XLEN-1:0] wb_d,
    output reg_idx_t        wb_dsel,
    output logic            wb_wen
);

    wb_req_t ld_req, lq_head, sel_req;
    wb_src_e sel_src;
    logic    lq_push, lq_pop, lq_full, lq_empty;
    logic [$clog2(LQ_DEPTH):0] lq_count;
    logic    unused_lq_count;

    logic            wb_wen_q, wb_wen_d;
    logic [XLEN-1:0] wb_d_q, wb_d_d;
    reg_idx_t        wb_dsel_q, wb_dsel_d;
    logic [NREG-1:0] busy_q, busy_d;

    // Ready depends only on FIFO occupancy; held low while in reset.
    assign ld_ready = rst_n & ~lq_full;
    assign lq_push  = ld_valid & ld_ready;
    assign ld_req   = '{rd: ld_rd, data: ld_data};
    // Occupancy is exposed by the FIFO but arbitration needs only full/empty.
    assign unused_lq_count = ^lq_count;

    sync_fifo #(
        .WIDTH ($bits(wb_req_t)),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lq_push),
        .din   (ld_req),
        .pop   (lq_pop),
        .dout  (lq_head),
        .full  (lq_full),
        .empty (lq_empty),
        .count (lq_count)
    );

    // Source select: ALU first, else drain the load FIFO head (no bypass).
    always_comb begin
        sel_src = WB_NONE;
        sel_req = lq_head;
        lq_pop  = 1'b0;
        if (alu_valid) begin
            sel_src = WB_ALU;
            sel_req = '{rd: alu_rd, data: alu_data};
        end else if (!lq_empty) begin
            sel_src = WB_LD;
            lq_pop  = 1'b1;
        end
    end

    // Registered write port; data/select hold when nothing is written.
    always_comb begin
        wb_wen_d  = (sel_src != WB_NONE);
        wb_d_d    = wb_d_q;
        wb_dsel_d = wb_dsel_q;
        if (wb_wen_d) begin
            wb_d_d    = sel_req.data;
            wb_dsel_d = sel_req.rd;
        end
    end

    // Pending-load bitmap: pop clears, issue sets, set wins, x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (lq_pop) begin
            busy_d[lq_head.rd] = 1'b0;
        end
        if (iss_ld && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wen_q  <= 1'b0;
            wb_d_q    <= '0;
            wb_dsel_q <= '0;
            busy_q    <= '0;
        end else begin
            wb_wen_q  <= wb_wen_d;
            wb_d_q    <= wb_d_d;
            wb_dsel_q <= wb_dsel_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_wen  = wb_wen_q;
    assign wb_d    = wb_d_q;
    assign wb_dsel = wb_dsel_q;
    assign busy    = busy_q;

`ifdef WB_TRACE_EN
    wb_src_e wb_src_q;

    // Track which source produced the write currently on the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_src_q <= WB_NONE;
        else        wb_src_q <= sel_src;
    end

    // Print every write presented to the register file.
    always_ff @(posedge clk) begin
        if (wb_wen_q) begin
            $display("%0t WB %s rd=%0d data=%h", $time,
                     (wb_src_q == WB_ALU) ? "ALU" : "LD", wb_dsel_q, wb_d_q);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a scoreboard: stimulus pushes
// expected writes, a negedge monitor pops and compares each wb_wen pulse.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, ld_valid, iss_ld;
    reg_idx_t        alu_rd, ld_rd, iss_rd;
    logic [31:0]     alu_data, ld_data;
    logic            ld_ready;
    logic [31:0]     busy;
    logic [31:0]     wb_d;
    reg_idx_t        wb_dsel;
    logic            wb_wen;

    int checks = 0;
    int errors = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;

    regfile_wb_arbiter #(.XLEN(32), .NREG(32), .LQ_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_ld    (iss_ld),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .wb_d      (wb_d),
        .wb_dsel   (wb_dsel),
        .wb_wen    (wb_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input int rd, input logic [31:0] data);
        wb_req_t r;
        r.rd   = reg_idx_t'(rd);
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write", wb_dsel, wb_d);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_dsel", 64'(wb_dsel), 64'(mon_e.rd));
                chk("wb_d", 64'(wb_d), 64'(mon_e.data));
            end
        end
    end

    initial begin
        logic [7:0] exp_rdy;
        int j;
        logic acc;

        rst_n = 1'b0; alu_valid = 0; ld_valid = 0; iss_ld = 0;
        alu_rd = '0; ld_rd = '0; iss_rd = '0; alu_data = '0; ld_data = '0;
        #12;
        chk("rst_wb_wen", 64'(wb_wen), 0);
        chk("rst_wb_d", 64'(wb_d), 0);
        chk("rst_wb_dsel", 64'(wb_dsel), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ld_ready", 64'(ld_ready), 0);
        rst_n = 1'b1;
        tick();

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        expect_wb(5, 32'hDEADBEEF);
        tick();
        alu_valid = 0;
        chk("alu_wen_c2", 64'(wb_wen), 1);
        tick();
        chk("alu_wen_c3", 64'(wb_wen), 0);
        chk("hold_wb_d", 64'(wb_d), 64'h DEADBEEF);
        chk("hold_wb_dsel", 64'(wb_dsel), 5);

        // Load with idle ALU
        iss_ld = 1; iss_rd = 6;
        tick();
        iss_ld = 0;
        chk("busy6_set", 64'(busy[6]), 1);
        tick();
        tick();
        ld_valid = 1; ld_rd = 6; ld_data = 32'h12;
        chk("ld_ready_empty", 64'(ld_ready), 1);
        expect_wb(6, 32'h12);
        tick();
        ld_valid = 0;
        chk("ld_no_bypass", 64'(wb_wen), 0);
        chk("busy6_pending", 64'(busy[6]), 1);
        tick();
        chk("ld_wen", 64'(wb_wen), 1);
        chk("busy6_clear", 64'(busy[6]), 0);
        tick();

        // Contention: 4 ALU writes, 3 loads back-to-back
        for (int c = 0; c < 4; c++) expect_wb(10 + c, 32'hA0 + c);
        for (int k = 0; k < 3; k++) expect_wb(20 + k, 32'h100 + k);
        exp_rdy = 8'b1110_0011;
        j = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (c < 4);
            alu_rd    = reg_idx_t'(10 + c);
            alu_data  = 32'hA0 + c;
            ld_valid  = (j < 3);
            ld_rd     = reg_idx_t'(20 + j);
            ld_data   = 32'h100 + j;
            chk("ld_ready_cont", 64'(ld_ready), 64'(exp_rdy[c]));
            acc = ld_valid && ld_ready;
            tick();
            if (acc) j++;
        end
        alu_valid = 0; ld_valid = 0;
        chk("loads_accepted", 64'(j), 3);
        tick();

        // Set/clear collision on rd=7
        iss_ld = 1; iss_rd = 7;
        tick();
        iss_ld = 0;
        ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
        expect_wb(7, 32'h77);
        tick();
        ld_valid = 0;
        iss_ld = 1; iss_rd = 7;
        tick();
        iss_ld = 0;
        chk("busy7_set_wins", 64'(busy[7]), 1);
        ld_valid = 1; ld_rd = 7; ld_data = 32'h78;
        expect_wb(7, 32'h78);
        tick();
        ld_valid = 0;
        tick();
        chk("busy7_clear", 64'(busy[7]), 0);
        tick();

        // x0 handling
        iss_ld = 1; iss_rd = 0;
        tick();
        iss_ld = 0;
        chk("busy_x0", 64'(busy), 0);
        ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
        expect_wb(0, 32'h55);
        tick();
        ld_valid = 0;
        tick();
        chk("x0_wen", 64'(wb_wen), 1);
        chk("x0_dsel", 64'(wb_dsel), 0);
        tick();

        // Reset mid-operation with FIFO full
        iss_ld = 1; iss_rd = 3;
        tick();
        iss_ld = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
        expect_wb(1, 32'h1);
        tick();
        alu_rd = 2; alu_data = 32'h2;
        ld_rd = 4; ld_data = 32'h44;
        tick();
        chk("full_ld_ready", 64'(ld_ready), 0);
        chk("busy3_before_rst", 64'(busy[3]), 1);
        #1;
        rst_n = 1'b0; alu_valid = 0; ld_valid = 0;
        #1;
        chk("async_rst_wen", 64'(wb_wen), 0);
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_ready", 64'(ld_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ld_ready), 1);
        repeat (4) tick();
        chk("post_rst_wen", 64'(wb_wen), 0);
        chk("post_rst_busy", 64'(busy), 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
